// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART frame parser slice
package uart_pkg;

    typedef logic [2:0] err_code_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam err_code_t ERR_NONE    = 3'd0;
    localparam err_code_t ERR_BAD_LEN = 3'd1;
    localparam err_code_t ERR_CSUM    = 3'd2;
    localparam err_code_t ERR_TIMEOUT = 3'd3;
    localparam err_code_t ERR_OVERRUN = 3'd4;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload register file, one write port, async read port
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [DEPTH];

    // Contents are only read after a full frame has been written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles [SOF][LEN][PAYLOAD][CSUM] frames from rx byte strobes
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT,
    parameter int          MAX_LEN        = 16,
    parameter int          TIMEOUT_CYCLES = 2080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [4:0] out_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int              IDX_W     = $clog2(MAX_LEN);
    localparam int              TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [4:0]       len_q, len_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    err_code_t        err_code_q, err_code_d;

    logic             buf_we;
    logic [7:0]       buf_rd_data;
    logic             in_frame;
    logic             rd_last;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (wr_idx_q),
        .wr_data (rx_data),
        .rd_idx  (rd_idx_q),
        .rd_data (buf_rd_data)
    );

    assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign rd_last  = (5'(rd_idx_q) == (len_q - 5'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        csum_d      = csum_q;
        timer_d     = timer_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;

        if (in_frame) begin
            timer_d = rx_valid ? '0 : timer_q + TMR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    state_d = ST_LEN;
                    timer_d = '0;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_BAD_LEN;
                    end else begin
                        state_d  = ST_PAYLOAD;
                        len_d    = rx_data[4:0];
                        csum_d   = rx_data;
                        wr_idx_d = '0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ rx_data;
                    if (5'(wr_idx_q) == (len_q - 5'd1)) begin
                        state_d = ST_CSUM;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d    = ST_DRAIN;
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_last) begin
                        state_d  = ST_IDLE;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
                // The receiver cannot be stalled, so a byte arriving while draining is lost.
                if (rx_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte landing on the expiry cycle takes priority over the timeout.
        if (in_frame && !rx_valid && (timer_q == TMR_LIMIT)) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            csum_q      <= '0;
            timer_q     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            csum_q      <= csum_d;
            timer_q     <= timer_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = out_valid ? buf_rd_data : 8'h00;
    assign out_last  = out_valid && rd_last;
    assign out_len   = len_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - randomized self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [4:0] out_len;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    int total = 0;
    int bad   = 0;

    int ok_n = 0;
    int err_q[$];
    int out_q[$];

    bit ready_rand  = 1'b1;
    bit ready_force = 1'b0;

    logic       prev_hold;
    logic [7:0] prev_data;

    uart_frame_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_len   (out_len),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Records every observable event and enforces output stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (frame_ok || frame_err) check("ok_err_excl", frame_ok && frame_err, 0);
            if (frame_ok) ok_n <= ok_n + 1;
            if (frame_err) err_q.push_back(int'(err_code));
            if (out_valid && out_ready) out_q.push_back(int'({out_len, out_last, out_data}));
            prev_hold <= out_valid && !out_ready;
            prev_data <= out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    function automatic logic [7:0] xor_csum(input logic [7:0] len, input logic [7:0] pl[$]);
        logic [7:0] c = len;
        foreach (pl[i]) c ^= pl[i];
        return c;
    endfunction

    // Waits (bounded) for the predicted outcome, then compares all events since the snapshot.
    task automatic verify(input string tag, input int ok0, input int e0, input int o0,
                          input int exp_err, input logic [7:0] len, input logic [7:0] pl[$]);
        int n_exp;
        n_exp = (exp_err == 0) ? int'(len) : 0;
        for (int t = 0; t < 800; t++) begin
            if ((exp_err == 0) && (out_q.size() - o0 >= n_exp)) break;
            if ((exp_err != 0) && (err_q.size() > e0)) break;
            tick();
        end
        repeat (3) tick();
        check({tag, "_ok_cnt"}, ok_n - ok0, (exp_err == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, err_q.size() - e0, (exp_err != 0) ? 1 : 0);
        if ((exp_err != 0) && (err_q.size() > e0)) check({tag, "_err_code"}, err_q[e0], exp_err);
        check({tag, "_out_cnt"}, out_q.size() - o0, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (o0 + i < out_q.size())
                check({tag, "_out_beat"}, out_q[o0 + i],
                      int'({len[4:0], (i == n_exp - 1), pl[i]}));
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] len, input logic [7:0] pl[$],
                            input bit bad_csum, input int gap_max);
        int ok0, e0, o0, exp_err;
        logic [7:0] b;
        ok0 = ok_n;
        e0  = err_q.size();
        o0  = out_q.size();
        if ((len == 0) || (len > 16)) exp_err = 1;
        else if (bad_csum)            exp_err = 2;
        else                          exp_err = 0;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, $urandom_range(0, gap_max));
        end
        send_byte(8'hA5, $urandom_range(0, gap_max));
        send_byte(len, $urandom_range(0, gap_max));
        if (exp_err != 1) begin
            foreach (pl[i]) send_byte(pl[i], $urandom_range(0, gap_max));
            b = xor_csum(len, pl);
            if (bad_csum) b ^= 8'(1 << $urandom_range(0, 7));
            send_byte(b, 0);
        end
        verify(tag, ok0, e0, o0, exp_err, len, pl);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] len;
        int ok0, e0, o0;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_len", out_len, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();

        pl = '{8'h11, 8'h22, 8'h33};
        do_frame("good3", 8'd3, pl, 1'b0, 0);
        pl = '{8'h10, 8'h20};
        do_frame("bad_csum", 8'd2, pl, 1'b1, 0);
        pl.delete();
        do_frame("len0", 8'd0, pl, 1'b0, 0);
        do_frame("len17", 8'h11, pl, 1'b0, 0);
        pl = '{8'h42};
        do_frame("len1", 8'd1, pl, 1'b0, 1);
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
        do_frame("len16", 8'd16, pl, 1'b0, 1);

        // Byte arriving exactly on the last allowed idle clock is still accepted.
        ok0 = ok_n; e0 = err_q.size(); o0 = out_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        repeat (2080) tick();
        send_byte(8'h20, 0);
        send_byte(8'h32, 0);
        pl = '{8'h10, 8'h20};
        verify("to_edge", ok0, e0, o0, 0, 8'd2, pl);

        e0 = err_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        repeat (2080) tick();
        check("to_early", err_q.size() - e0, 0);
        tick();
        check("to_flag", frame_err, 1);
        check("to_code", err_code, 3);
        tick();
        check("to_pulse", frame_err, 0);
        pl = '{8'h7E};
        do_frame("after_to", 8'd1, pl, 1'b0, 0);

        ready_rand  = 1'b0;
        ready_force = 1'b0;
        ok0 = ok_n; o0 = out_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'h13, 0);
        repeat (50) tick();
        check("ovr_valid", out_valid, 1);
        check("ovr_data", out_data, 8'hAA);
        check("ovr_last", out_last, 0);
        send_byte(8'h55, 0);
        check("ovr_flag", frame_err, 1);
        check("ovr_code", err_code, 4);
        tick();
        check("ovr_data_hold", out_data, 8'hAA);
        e0 = err_q.size();
        ready_rand = 1'b1;
        pl = '{8'hAA, 8'hBB};
        verify("ovr_drain", ok0, e0, o0, 0, 8'd2, pl);

        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_code", err_code, 0);
        check("mid_rst_len", out_len, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        pl = '{8'hDE, 8'hAD, 8'hBE};
        do_frame("post_rst", 8'd3, pl, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            len = 8'($urandom_range(0, 18));
            pl.delete();
            if (len <= 16) begin
                for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
            end
            do_frame("rand", len, pl, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
